fp16_mul_issue_buf: RTL and testbench
=====================================

# fp16_mul_issue_buf

Issue controller and in-order result buffer wrapped around the FP16 multiplier stage. Accepts operand pairs on a valid/ready handshake and drives the multiplier's single-cycle `valid`/`a`/`b` strobe. Captures the multiplier's `y`/`ready` pulses, which cannot be back-pressured, into a slot array, and re-presents them downstream with backpressure. Credit gating guarantees that every issued operation already owns a buffer slot, so no result is ever dropped.

## Interface
Parameters:
- `DEPTH`, 8: number of result slots; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH)+1`: pointer/credit width, including the wrap bit.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset; synchronous, active-low; shared with the multiplier.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  slot credit available.
- `in_a`, `in_b`  in  16  FP16 operands.
- `in_last`  in  1  sideband marking the final element of a vector.
- `mul_valid`  out  1  one-cycle issue strobe to the multiplier.
- `mul_a`, `mul_b`  out  16  registered operands to the multiplier.
- `mul_y`  in  16  multiplier result.
- `mul_ready`  in  1  result-valid pulse from the multiplier.
- `out_valid`  out  1  buffered result available.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  16  FP16 product.
- `out_last`  out  1  `in_last` of the matching issue.
- `out_nan`  out  1  `out_data` is NaN: exponent = 5'h1F and mantissa ≠ 0.
- `credits`  out  CNT_W  free slots, `DEPTH - (wr_iss - rd)`.
- `err_spurious`  out  1  sticky flag: a `mul_ready` arrived with nothing outstanding.

## Operation
- Three CNT_W pointers, all with a wrap bit:
  - `wr_iss`: slot reserved at issue.
  - `wr_res`: slot filled at result arrival.
  - `rd`: slot popped downstream.
- Slot array holds `{data[15:0], last}`.
- Issue fire = `in_valid & in_ready`:
  - `slot[wr_iss].last <= in_last`.
  - `wr_iss++`.
  - `mul_a <= in_a`, `mul_b <= in_b`, `mul_valid <= 1`; otherwise `mul_valid <= 0`.
- `in_ready = (credits != 0)`, computed from registered pointers only. A same-cycle pop does not free a credit until the next cycle; there is no bypass.
- Result capture: when `mul_ready` and `wr_res != wr_iss`, `slot[wr_res].data <= mul_y` and `wr_res++`.
- Spurious result: `mul_ready` with `wr_res == wr_iss` is ignored and sets `err_spurious`. The flag is cleared only by reset.
- Output:
  - `out_valid = (rd != wr_res)`.
  - `out_data`/`out_last` come combinationally from `slot[rd]`.
  - A pop (`out_valid & out_ready`) does `rd++`.
- Issue, result capture and pop may all occur in the same cycle; each pointer updates independently.
- Results are delivered strictly in issue order; the multiplier is in-order.
- Pointer arithmetic is modulo 2^CNT_W.
  - Full: `wr_iss - rd == DEPTH`.
  - Empty output: `rd == wr_res`.
  - Slot index = low `$clog2(DEPTH)` bits.

## Timing
- Reset values:
  - All pointers 0.
  - `mul_valid` 0, `mul_a`/`mul_b` 0.
  - `err_spurious` 0, `out_valid` 0.
  - `in_ready` 1, `credits` = DEPTH.
  - Slot contents don't-care; `out_data` is unspecified while `out_valid` = 0.
- Issue latency: fire at cycle t gives `mul_valid` = 1 at t+1.
- Result latency: `mul_ready` at cycle r gives `out_valid` = 1 at r+1 if the buffer was empty. End-to-end latency is therefore the multiplier latency + 2.
- Throughput: one issue and one pop per cycle, sustained, with `DEPTH` ≥ multiplier latency + 2.
- `in_ready` drops in the cycle after the issue that takes the last credit.
- Reset mid-operation: all in-flight state is discarded. The multiplier is flushed by the shared `rstn`; any stray `mul_ready` after reset sets `err_spurious`.
- `out_valid`/`out_data` hold stable while `out_ready` = 0.

## Structure
- `fp16_pkg` (shared package) provides:
  - `FP16_EXP_W` = 5, `FP16_MAN_W` = 10.
  - `typedef fp16_t`.
  - Function `fp16_is_nan(fp16_t)`.
  - This block uses `fp16_is_nan` for `out_nan`.
- Single module, no sub-module. The slot array is small flops, with no RAM inference.

## Test plan
- Single op: issue a = 16'h3C00, b = 16'h4000, last = 1; model returns 16'h4000 after 4 cycles → `mul_valid` at t+1, `out_data` 16'h4000, `out_last` 1 at r+1, `credits` back to 8 after the pop.
- Fill, DEPTH = 8: hold `out_ready` = 0 and issue 10 ops → exactly 8 accepted, `in_ready` = 0 and `credits` = 0. Raise `out_ready` → 8 results emerge in order, then the remaining 2 are accepted.
- Streaming: issue, result and pop every cycle for 100 ops with random `in_last` → zero stalls after warm-up, all data and last flags matched in order.
- Simultaneous events with the buffer full: pop and a new `in_valid` in the same cycle → the issue is not accepted that cycle and is accepted the next.
- Spurious: assert `mul_ready` with nothing outstanding → `err_spurious` = 1 and remains set, no pointer moves, `out_valid` stays 0.
- NaN and reset: result 16'h7E00 → `out_nan` = 1, and 16'h7C00 (Inf) → `out_nan` = 0. Then assert `rstn` = 0 with 3 results in flight → all outputs return to their reset values and `credits` = 8.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, the FP16 word type and a NaN classifier.
package fp16_pkg;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;

  typedef logic [FP16_EXP_W+FP16_MAN_W:0] fp16_t;

  // NaN: exponent all ones and a non-zero mantissa (all-ones exponent with zero mantissa is Inf).
  function automatic logic fp16_is_nan(fp16_t v);
    return (&v[FP16_MAN_W +: FP16_EXP_W]) && (|v[FP16_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp16_mul_issue_buf.sv
// Issue controller and in-order result buffer around the FP16 multiplier.
// Each issue reserves a slot up front, so the multiplier's unstoppable result
// pulses always have somewhere to land.
module fp16_mul_issue_buf
  import fp16_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             mul_valid,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_y,
  input  logic             mul_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_nan,
  output logic [CNT_W-1:0] credits,
  output logic             err_spurious
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] wr_iss_q, wr_iss_d;
  logic [CNT_W-1:0] wr_res_q, wr_res_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             mul_valid_q, mul_valid_d;
  logic [15:0]      mul_a_q, mul_a_d;
  logic [15:0]      mul_b_q, mul_b_d;
  logic             err_q, err_d;

  fp16_t            slot_data_q [DEPTH];
  fp16_t            slot_data_d [DEPTH];
  logic [DEPTH-1:0] slot_last_q, slot_last_d;

  logic [CNT_W-1:0] used;
  logic             fire, capture, spurious, pop, outstanding;

  // Handshake decode; credits come from registered pointers only, so a pop frees
  // its slot for issue one cycle later.
  always_comb begin
    used        = wr_iss_q - rd_q;
    credits     = CNT_W'(DEPTH) - used;
    in_ready    = (credits != '0);
    outstanding = (wr_res_q != wr_iss_q);
    out_valid   = (rd_q != wr_res_q);
    fire        = in_valid & in_ready;
    capture     = mul_ready & outstanding;
    spurious    = mul_ready & ~outstanding;
    pop         = out_valid & out_ready;
    out_data    = slot_data_q[rd_q[IDX_W-1:0]];
    out_last    = slot_last_q[rd_q[IDX_W-1:0]];
    out_nan     = fp16_is_nan(out_data);
  end

  // Next-state for pointers, the issue register and the sticky error flag.
  always_comb begin
    wr_iss_d    = wr_iss_q;
    wr_res_d    = wr_res_q;
    rd_d        = rd_q;
    mul_valid_d = fire;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    err_d       = err_q | spurious;
    if (fire) begin
      wr_iss_d = wr_iss_q + CNT_W'(1);
      mul_a_d  = in_a;
      mul_b_d  = in_b;
    end
    if (capture) begin
      wr_res_d = wr_res_q + CNT_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + CNT_W'(1);
    end
  end

  // Next-state for the slot array: sideband written at issue, data at result arrival.
  always_comb begin
    slot_data_d = slot_data_q;
    slot_last_d = slot_last_q;
    if (fire) begin
      slot_last_d[wr_iss_q[IDX_W-1:0]] = in_last;
    end
    if (capture) begin
      slot_data_d[wr_res_q[IDX_W-1:0]] = mul_y;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_iss_q    <= '0;
      wr_res_q    <= '0;
      rd_q        <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_iss_q    <= wr_iss_d;
      wr_res_q    <= wr_res_d;
      rd_q        <= rd_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      err_q       <= err_d;
    end
  end

  // Slot storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
    slot_last_q <= slot_last_d;
  end

  assign mul_valid    = mul_valid_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_fp16_mul_issue_buf.sv
// Bench for fp16_mul_issue_buf: a fixed-latency stand-in multiplier, a queue-based
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_fp16_mul_issue_buf;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_valid;
  logic [15:0]      mul_a, mul_b, mul_y;
  logic             mul_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_last;
  logic             out_nan;
  logic [CNT_W-1:0] credits;
  logic             err_spurious;
  logic             inject = 1'b0;
  logic             chk_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fp16_mul_issue_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .mul_ready(mul_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_nan(out_nan), .credits(credits), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  // Truncating FP16 multiply for normal operands; Inf/NaN in a passes a through.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    int          e;
    logic [21:0] m;
    logic [9:0]  man;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return a;
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    m = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    if (m[21]) begin
      e++;
      man = m[20:11];
    end else begin
      man = m[19:10];
    end
    return {a[15] ^ b[15], e[4:0], man};
  endfunction

  // Stand-in multiplier: fixed latency, flushed by the shared reset.
  logic [LAT-1:0] pv;
  logic [15:0]    pa [LAT];
  logic [15:0]    pb [LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mul_valid};
      pa[0] <= mul_a;
      pb[0] <= mul_b;
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end
  assign mul_ready = pv[LAT-1] | inject;
  assign mul_y     = pv[LAT-1] ? fmul(pa[LAT-1], pb[LAT-1]) : 16'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of issued-not-popped results, count of those already arrived.
  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } ent_t;
  ent_t        mq[$];
  int          m_arrived = 0;
  logic        m_mv = 1'b0;
  logic [15:0] m_ma = '0;
  logic [15:0] m_mb = '0;
  logic        m_err = 1'b0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", in_ready, mq.size() < DEPTH);
      check("credits", credits, DEPTH - mq.size());
      check("out_valid", out_valid, m_arrived > 0);
      if (m_arrived > 0) begin
        ent_t        h;
        logic        nan;
        h   = mq[0];
        nan = (h.d[14:10] == 5'h1F) && (h.d[9:0] != 10'h0);
        check("out_data", out_data, h.d);
        check("out_last", out_last, h.l);
        check("out_nan", out_nan, nan);
      end
      check("mul_valid", mul_valid, m_mv);
      check("mul_a", mul_a, m_ma);
      check("mul_b", mul_b, m_mb);
      check("err_spurious", err_spurious, m_err);
    end
    if (!rstn) begin
      mq.delete();
      m_arrived = 0;
      m_mv  = 1'b0;
      m_ma  = '0;
      m_mb  = '0;
      m_err = 1'b0;
    end else begin
      bit fire, pop, cap, spur;
      fire = in_valid && (mq.size() < DEPTH);
      pop  = (m_arrived > 0) && out_ready;
      cap  = mul_ready && (mq.size() > m_arrived);
      spur = mul_ready && !(mq.size() > m_arrived);
      if (pop) begin
        void'(mq.pop_front());
        m_arrived--;
      end
      if (cap) m_arrived++;
      if (fire) begin
        mq.push_back({fmul(in_a, in_b), in_last});
        m_ma = in_a;
        m_mb = in_b;
      end
      m_mv = fire;
      if (spur) m_err = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
    check("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (credits != CNT_W'(DEPTH) && n < 200) begin
      step();
      n++;
    end
    check("drain", credits, DEPTH);
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] op_a(input int i);
    logic [9:0] m;
    m = 10'(i * 37);
    return {1'b0, 5'd15, m};
  endfunction

  initial begin
    int acc, cyc, stalls;
    bit was;

    // Reset state
    repeat (2) step();
    rstn = 1'b1;
    step();
    chk_en = 1'b1;
    check("rst in_ready", in_ready, 1'b1);
    check("rst credits", credits, 8);
    check("rst out_valid", out_valid, 1'b0);
    check("rst err", err_spurious, 1'b0);
    check("rst mul_valid", mul_valid, 1'b0);

    // Single op: 1.0 * 2.0 = 2.0
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    check("single mul_valid", mul_valid, 1'b1);
    check("single mul_a", mul_a, 16'h3C00);
    wait_out_valid(20);
    check("single data", out_data, 16'h4000);
    check("single last", out_last, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    check("single credits", credits, 8);

    // Fill with out_ready low: exactly DEPTH accepted
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 18; c++) begin
      in_a = op_a(acc); in_b = 16'h4000 + 16'(acc); in_last = acc[0];
      was = in_ready;
      step();
      if (was) acc++;
    end
    check("fill accepted", acc, 8);
    check("fill in_ready", in_ready, 1'b0);
    check("fill credits", credits, 0);
    out_ready = 1'b1;
    cyc = 0;
    while (acc < 10 && cyc < 50) begin
      in_a = op_a(acc); in_b = 16'h4000 + 16'(acc); in_last = acc[0];
      was = in_ready;
      step();
      if (was) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    check("fill rest", acc, 10);
    drain();

    // Streaming: one issue and one pop per cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    acc = 0; cyc = 0; stalls = 0;
    while (acc < 100 && cyc < 400) begin
      in_a = {1'b0, 5'($urandom_range(10, 20)), 10'($urandom)};
      in_b = {1'b1, 5'($urandom_range(10, 20)), 10'($urandom)};
      in_last = 1'($urandom);
      was = in_ready;
      step();
      if (was) acc++;
      else if (acc >= 10) stalls++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream count", acc, 100);
    check("stream stalls", stalls, 0);
    drain();

    // Full buffer, pop and new issue in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    while (in_ready && acc < 20) begin
      in_a = op_a(acc + 50); in_b = 16'h3800; in_last = 1'b0;
      step();
      acc++;
    end
    in_valid = 1'b0;
    repeat (LAT + 4) step();
    check("full credits", credits, 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h4200; in_b = 16'h4200; in_last = 1'b1;
    check("full no bypass", in_ready, 1'b0);
    step();
    check("full next ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    drain();

    // Spurious result
    repeat (LAT + 4) step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("spur err", err_spurious, 1'b1);
    check("spur out_valid", out_valid, 1'b0);
    check("spur credits", credits, 8);
    repeat (3) step();
    check("spur sticky", err_spurious, 1'b1);
    check("spur still empty", out_valid, 1'b0);

    // NaN and Inf classification
    in_valid = 1'b1; in_a = 16'h7E00; in_b = 16'h3C00; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    wait_out_valid(20);
    check("nan flag", out_nan, 1'b1);
    check("nan data", out_data, 16'h7E00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h7C00; in_b = 16'h3C00;
    step();
    in_valid = 1'b0;
    wait_out_valid(20);
    check("inf flag", out_nan, 1'b0);
    check("inf data", out_data, 16'h7C00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset with three results in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = op_a(i + 90); in_b = 16'h4400; in_last = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    rstn = 1'b0;
    step();
    check("mid-rst credits", credits, 8);
    check("mid-rst out_valid", out_valid, 1'b0);
    check("mid-rst mul_valid", mul_valid, 1'b0);
    check("mid-rst mul_a", mul_a, 16'h0);
    check("mid-rst err", err_spurious, 1'b0);
    check("mid-rst in_ready", in_ready, 1'b1);
    step();
    rstn = 1'b1;
    repeat (LAT + 4) step();
    check("post-rst err", err_spurious, 1'b0);
    check("post-rst out_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
